// File: rtl/cache_arb_pkg.sv
// Shared types for the cache fill arbiter: FSM state encoding, requester IDs,
// the read burst length and the round-robin rotation helper.
package cache_arb_pkg;

   localparam int BURST_LEN = 4;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_RD_CMD   = 3'd1,
      S_RD_WAIT  = 3'd2,
      S_RD_BURST = 3'd3,
      S_WR_CMD   = 3'd4
   } state_e;

   typedef enum logic [1:0] {
      REQ_C0 = 2'd0,
      REQ_C1 = 2'd1,
      REQ_WR = 2'd2
   } req_id_e;

   // Rotation order c0 -> c1 -> wr -> c0
   function automatic req_id_e rr_next(input req_id_e id);
      case (id)
         REQ_C0:  rr_next = REQ_C1;
         REQ_C1:  rr_next = REQ_WR;
         default: rr_next = REQ_C0;
      endcase
   endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// Three-way round-robin arbiter with internal priority pointer.
// Ports:
//   clk, reset_n  clock, synchronous active-low reset (pointer -> c0)
//   req_i[2:0]    requests: [0] c0, [1] c1, [2] wr
//   advance_i     when high and a grant is given, pointer moves past the winner
//   grant_o[2:0]  one-hot grant (combinational)
//   grant_id_o    encoded ID of the granted requester (REQ_C0 when none)
module rr_arbiter3
   import cache_arb_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic [2:0] req_i,
   input  logic       advance_i,
   output logic [2:0] grant_o,
   output req_id_e    grant_id_o
);

   req_id_e ptr_q;

   always_comb begin
      grant_o = 3'b000;
      case (ptr_q)
         REQ_C1: begin
            if (req_i[1])      grant_o = 3'b010;
            else if (req_i[2]) grant_o = 3'b100;
            else if (req_i[0]) grant_o = 3'b001;
         end
         REQ_WR: begin
            if (req_i[2])      grant_o = 3'b100;
            else if (req_i[0]) grant_o = 3'b001;
            else if (req_i[1]) grant_o = 3'b010;
         end
         default: begin
            if (req_i[0])      grant_o = 3'b001;
            else if (req_i[1]) grant_o = 3'b010;
            else if (req_i[2]) grant_o = 3'b100;
         end
      endcase
   end

   always_comb begin
      grant_id_o = REQ_C0;
      if (grant_o[1]) grant_id_o = REQ_C1;
      if (grant_o[2]) grant_id_o = REQ_WR;
   end

   always_ff @(posedge clk) begin
      if (!reset_n)
         ptr_q <= REQ_C0;
      else if (advance_i && (grant_o != 3'b000))
         ptr_q <= rr_next(grant_id_o);
   end

endmodule

// File: rtl/cache_fill_arbiter.sv
// Shares one SDRAM controller port between two cache fill requesters and the
// CPU write-through path. Reads are issued critical-word-first and the 4-beat
// burst is forwarded onto fill_data_o with a fill pulse on the first word.
//
// state      | meaning
// S_IDLE     | pick next requester round-robin, latch command fields
// S_RD_CMD   | sd_req_o high, sd_we_o low, wait for sd_ack_i
// S_RD_WAIT  | read accepted, wait for first beat
// S_RD_BURST | forward beats 2..4; a missing beat sets burst_err_o
// S_WR_CMD   | sd_req_o high, sd_we_o high, wait for sd_ack_i
//
// Ports: clk/reset_n (sync active-low); cN_req_i/cN_addr_i/cN_fill_o fill
// interface per cache; fill_data_o shared fill word bus; wr_* write path;
// sd_* SDRAM controller command/read port; burst_err_o sticky error.
module cache_fill_arbiter
   import cache_arb_pkg::*;
#(
   parameter int ADDR_W    = 26,
   parameter int BURST_LEN = cache_arb_pkg::BURST_LEN
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              c0_req_i,
   input  logic [ADDR_W-1:0] c0_addr_i,
   output logic              c0_fill_o,
   input  logic              c1_req_i,
   input  logic [ADDR_W-1:0] c1_addr_i,
   output logic              c1_fill_o,
   output logic [15:0]       fill_data_o,
   input  logic              wr_req_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [15:0]       wr_data_i,
   input  logic [1:0]        wr_be_n_i,
   output logic              wr_ack_o,
   output logic              sd_req_o,
   output logic              sd_we_o,
   output logic [ADDR_W-1:0] sd_addr_o,
   output logic [15:0]       sd_wdata_o,
   output logic [1:0]        sd_dqm_o,
   input  logic              sd_ack_i,
   input  logic              sd_rvalid_i,
   input  logic [15:0]       sd_rdata_i,
   output logic              burst_err_o
);

   localparam logic [1:0] LAST_BEAT = 2'(BURST_LEN - 1);

   state_e            state_q, state_d;
   req_id_e           gnt_q, gnt_d;
   logic [1:0]        beat_q, beat_d;
   logic [ADDR_W-1:0] sd_addr_q, sd_addr_d;
   logic [15:0]       sd_wdata_q, sd_wdata_d;
   logic [1:0]        sd_dqm_q, sd_dqm_d;
   logic [15:0]       fill_data_q, fill_data_d;
   logic              c0_fill_q, c0_fill_d;
   logic              c1_fill_q, c1_fill_d;
   logic              wr_ack_q, wr_ack_d;
   logic              burst_err_q, burst_err_d;

   logic [2:0]        grant;
   req_id_e           grant_id;
   logic              first_beat;

   rr_arbiter3 u_rr (
      .clk        (clk),
      .reset_n    (reset_n),
      .req_i      ({wr_req_i, c1_req_i, c0_req_i}),
      .advance_i  (state_q == S_IDLE),
      .grant_o    (grant),
      .grant_id_o (grant_id)
   );

   // State and output registers
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         gnt_q       <= REQ_C0;
         beat_q      <= 2'd0;
         sd_addr_q   <= '0;
         sd_wdata_q  <= 16'h0000;
         sd_dqm_q    <= 2'b11;
         fill_data_q <= 16'h0000;
         c0_fill_q   <= 1'b0;
         c1_fill_q   <= 1'b0;
         wr_ack_q    <= 1'b0;
         burst_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         beat_q      <= beat_d;
         sd_addr_q   <= sd_addr_d;
         sd_wdata_q  <= sd_wdata_d;
         sd_dqm_q    <= sd_dqm_d;
         fill_data_q <= fill_data_d;
         c0_fill_q   <= c0_fill_d;
         c1_fill_q   <= c1_fill_d;
         wr_ack_q    <= wr_ack_d;
         burst_err_q <= burst_err_d;
      end
   end

   // Next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (grant[0] || grant[1]) state_d = S_RD_CMD;
            else if (grant[2])        state_d = S_WR_CMD;
         end
         S_RD_CMD: begin
            // Controller may return the first beat in the accept cycle
            if (sd_ack_i) state_d = sd_rvalid_i ? S_RD_BURST : S_RD_WAIT;
         end
         S_RD_WAIT: begin
            if (sd_rvalid_i) state_d = S_RD_BURST;
         end
         S_RD_BURST: begin
            if (sd_rvalid_i && (beat_q == LAST_BEAT)) state_d = S_IDLE;
         end
         S_WR_CMD: begin
            if (sd_ack_i) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs and datapath next values
   assign first_beat = sd_rvalid_i &&
                       (((state_q == S_RD_CMD) && sd_ack_i) || (state_q == S_RD_WAIT));

   always_comb begin
      sd_req_o    = (state_q == S_RD_CMD) || (state_q == S_WR_CMD);
      sd_we_o     = (state_q == S_WR_CMD);
      gnt_d       = gnt_q;
      beat_d      = beat_q;
      sd_addr_d   = sd_addr_q;
      sd_wdata_d  = sd_wdata_q;
      sd_dqm_d    = sd_dqm_q;
      fill_data_d = fill_data_q;
      c0_fill_d   = 1'b0;
      c1_fill_d   = 1'b0;
      wr_ack_d    = 1'b0;
      burst_err_d = burst_err_q;

      case (state_q)
         S_IDLE: begin
            if (grant != 3'b000) begin
               gnt_d  = grant_id;
               beat_d = 2'd0;
               if (grant[2]) begin
                  sd_addr_d  = {wr_addr_i[ADDR_W-1:1], 1'b0};
                  sd_wdata_d = wr_data_i;
                  sd_dqm_d   = wr_be_n_i;
               end else begin
                  sd_addr_d = grant[1] ? {c1_addr_i[ADDR_W-1:1], 1'b0}
                                       : {c0_addr_i[ADDR_W-1:1], 1'b0};
                  sd_dqm_d  = 2'b00;
               end
            end
            if (sd_rvalid_i) burst_err_d = 1'b1;
         end
         S_RD_CMD: begin
            if (sd_rvalid_i && !sd_ack_i) burst_err_d = 1'b1;
         end
         S_RD_BURST: begin
            if (sd_rvalid_i) begin
               fill_data_d = sd_rdata_i;
               beat_d      = beat_q + 2'd1;   // wraps 3 -> 0 on the last beat
            end else begin
               burst_err_d = 1'b1;
            end
         end
         S_WR_CMD: begin
            if (sd_ack_i)    wr_ack_d    = 1'b1;
            if (sd_rvalid_i) burst_err_d = 1'b1;
         end
         default: ;
      endcase

      if (first_beat) begin
         fill_data_d = sd_rdata_i;
         beat_d      = 2'd1;
         c0_fill_d   = (gnt_q == REQ_C0);
         c1_fill_d   = (gnt_q == REQ_C1);
      end
   end

   assign c0_fill_o   = c0_fill_q;
   assign c1_fill_o   = c1_fill_q;
   assign fill_data_o = fill_data_q;
   assign wr_ack_o    = wr_ack_q;
   assign sd_addr_o   = sd_addr_q;
   assign sd_wdata_o  = sd_wdata_q;
   assign sd_dqm_o    = sd_dqm_q;
   assign burst_err_o = burst_err_q;

endmodule
